// File: rtl/data_memory_mp.sv
// Dual-port byte-enabled data memory with self-clearing init sequence.
// Write-first on both ports; port 1 wins overlapping lanes on collisions.
module data_memory_mp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              wr_en0,
  input  logic              wr_en1,
  input  logic [DATA_W/8-1:0] be0,
  input  logic [DATA_W/8-1:0] be1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              rd_en0,
  input  logic              rd_en1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              misalign0,
  output logic              misalign1
);

  localparam int NB  = DATA_W / 8;
  localparam int OFS = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   cnt, cnt_n;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]   idx0, idx1;
  logic            al0, al1;
  logic            acc0, acc1;
  logic            we0, we1, re0, re1;
  logic [DATA_W-1:0] m0, m1;
  logic            unused_addr;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old,
    input logic [DATA_W-1:0] wd,
    input logic [NB-1:0]     be,
    input logic              en
  );
    logic [DATA_W-1:0] r;
    r = old;
    for (int k = 0; k < NB; k++)
      if (en && be[k])
        r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  assign ready = (state == RUN);

  assign idx0 = addr0[OFS+AW-1:OFS];
  assign idx1 = addr1[OFS+AW-1:OFS];
  assign al0  = (addr0[OFS-1:0] == '0);
  assign al1  = (addr1[OFS-1:0] == '0);

  assign unused_addr = &{1'b0, addr0[31:OFS+AW],
                         addr1[31:OFS+AW]};

  assign acc0 = ready && (wr_en0 || rd_en0);
  assign acc1 = ready && (wr_en1 || rd_en1);
  assign we0  = acc0 && al0 && wr_en0;
  assign we1  = acc1 && al1 && wr_en1;
  assign re0  = acc0 && al0 && rd_en0;
  assign re1  = acc1 && al1 && rd_en1;

  // Post-write view of each port's word, port 1 applied last
  always_comb begin
    m0 = merge(mem[idx0], wdata0, be0, we0);
    m0 = merge(m0, wdata1, be1, we1 && (idx1 == idx0));
    m1 = merge(mem[idx1], wdata0, be0, we0 && (idx0 == idx1));
    m1 = merge(m1, wdata1, be1, we1);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == INIT) begin
      cnt_n = cnt + AW'(1);
      if (cnt == AW'(DEPTH - 1))
        state_n = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else begin
        if (we0) mem[idx0] <= m0;
        if (we1) mem[idx1] <= m1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0    <= '0;
      rdata1    <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      misalign0 <= 1'b0;
      misalign1 <= 1'b0;
    end else begin
      rvalid0   <= re0;
      rvalid1   <= re1;
      misalign0 <= acc0 && !al0;
      misalign1 <= acc1 && !al1;
      if (re0) rdata0 <= m0;
      if (re1) rdata1 <= m1;
    end
  end

endmodule

// File: tb/tb_data_memory_mp.sv
// Directed bench for data_memory_mp at DATA_W=32, DEPTH=16.
// Expected values are hand-computed constants.
module tb_data_memory_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic        wr_en0, wr_en1, rd_en0, rd_en1;
  logic [3:0]  be0, be1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, misalign0, misalign1;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  always #5 clk = ~clk;

  data_memory_mp #(.DATA_W(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .wr_en0(wr_en0), .wr_en1(wr_en1),
    .be0(be0), .be1(be1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .rd_en0(rd_en0), .rd_en1(rd_en1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .misalign0(misalign0), .misalign1(misalign1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en0 = 0; wr_en1 = 0; rd_en0 = 0; rd_en1 = 0;
    be0 = 0; be1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] b);
    idle();
    wr_en0 = 1; addr0 = a; wdata0 = d; be0 = b;
    cyc();
    idle();
  endtask

  task automatic rd0(input logic [31:0] a);
    idle();
    rd_en0 = 1; addr0 = a;
    cyc();
    idle();
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (!ready && n < 40) begin
      cyc();
      n++;
    end
    chk(tag, n, 16);
  endtask

  initial begin
    idle();
    rst_n = 0;
    #3;
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_rvalid", {30'b0, rvalid0, rvalid1}, 0);
    chk("rst_misal", {30'b0, misalign0, misalign1}, 0);
    chk("rst_rdata0", rdata0, 0);
    cyc();
    cyc();
    rst_n = 1;

    // INIT with requests that must be ignored
    n = 0;
    while (!ready && n < 40) begin
      if (n == 2) begin
        wr_en0 = 1; rd_en0 = 1; addr0 = 32'd2;
        wdata0 = '1; be0 = 4'hF;
        wr_en1 = 1; rd_en1 = 1; addr1 = 32'd0;
        wdata1 = '1; be1 = 4'hF;
      end
      cyc();
      n++;
      if (n == 3) begin
        chk("init_rvalid", {30'b0, rvalid0, rvalid1}, 0);
        chk("init_misal", {31'b0, misalign0}, 0);
        idle();
      end
    end
    chk("init_len", n, 16);

    for (int a = 0; a < 64; a += 4) begin
      rd0(a);
      chk($sformatf("zero_%0d", a), rdata0, 0);
      if (a == 0) chk("rvalid_hi", {31'b0, rvalid0}, 1);
    end
    cyc();
    chk("rvalid_fall", {31'b0, rvalid0}, 0);

    // byte lanes and wrap-around
    wr0(0, 32'hFFFF_FFFF, 4'b1111);
    wr0(0, 32'h0000_0000, 4'b0101);
    rd0(0);
    chk("be_merge", rdata0, 32'hFF00_FF00);
    wr0(0, 32'h1234_5678, 4'b0000);
    rd0(0);
    chk("be_zero", rdata0, 32'hFF00_FF00);
    wr0(64, 32'h1234_5678, 4'b1111);
    rd0(0);
    chk("wrap", rdata0, 32'h1234_5678);
    cyc();
    chk("rdata_hold", rdata0, 32'h1234_5678);

    // collision with write-first read on port 1
    idle();
    wr_en0 = 1; addr0 = 8; wdata0 = 32'h1111_1111; be0 = 4'b1111;
    wr_en1 = 1; addr1 = 8; wdata1 = 32'h2222_2222; be1 = 4'b0011;
    rd_en1 = 1;
    cyc();
    idle();
    chk("coll_rd1", rdata1, 32'h1111_2222);
    chk("coll_rv1", {31'b0, rvalid1}, 1);
    rd0(8);
    chk("coll_rd0", rdata0, 32'h1111_2222);

    // same-port read+write
    idle();
    wr_en0 = 1; rd_en0 = 1; addr0 = 20;
    wdata0 = 32'hAABB_CCDD; be0 = 4'b1010;
    cyc();
    idle();
    chk("rw_same", rdata0, 32'hAA00_CC00);

    // dual read, different words
    idle();
    rd_en0 = 1; addr0 = 8; rd_en1 = 1; addr1 = 20;
    cyc();
    idle();
    chk("dual_rd0", rdata0, 32'h1111_2222);
    chk("dual_rd1", rdata1, 32'hAA00_CC00);

    // misaligned access on port 1
    wr0(4, 32'hCAFE_BABE, 4'b1111);
    idle();
    wr_en1 = 1; rd_en1 = 1; addr1 = 6;
    wdata1 = 32'h0; be1 = 4'b1111;
    cyc();
    idle();
    chk("mis_pulse", {31'b0, misalign1}, 1);
    chk("mis_norv", {31'b0, rvalid1}, 0);
    cyc();
    chk("mis_fall", {31'b0, misalign1}, 0);
    rd0(4);
    chk("mis_nowr", rdata0, 32'hCAFE_BABE);

    // wr_en low leaves word intact
    wr0(12, 32'h000F_FFFF, 4'b1111);
    idle();
    addr0 = 12; wdata0 = 32'h0000_FFFF; be0 = 4'b1111;
    cyc();
    rd0(12);
    chk("no_wr", rdata0, 32'h000F_FFFF);

    // reset mid-RUN while a read is in flight
    idle();
    rd_en0 = 1; addr0 = 12;
    cyc();
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_ready", {31'b0, ready}, 0);
    chk("mid_rst_rv", {31'b0, rvalid0}, 0);
    chk("mid_rst_rd", rdata0, 0);
    idle();
    cyc();
    rst_n = 1;
    wait_ready("reinit_len");
    rd0(12);
    chk("reinit_zero", rdata0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
